// File: rtl/instruction_loader.sv
// Instruction memory loader: takes a framed byte stream (0xA5, count hi,
// count lo, count*4 data bytes), packs big-endian 32-bit words and writes
// them to the instruction RAM starting at word 0. It holds the core in reset
// while the load is in progress.
module instruction_loader #(
    parameter int ADDR_W    = 16,
    parameter int MEM_WORDS = 65536
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [ADDR_W-1:0] wa,
    output logic [31:0]       wd,
    output logic              we,
    output logic              core_rst_n,
    output logic              done,
    output logic              error
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CNT_HI = 3'd1;
    localparam logic [2:0] S_CNT_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_FINISH = 3'd5;

    localparam logic [31:0] LP_MAX_WORDS = 32'(MEM_WORDS);

    logic [2:0]        r_state;
    logic [7:0]        r_cnt_hi;
    logic [15:0]       r_count;
    // One bit wider than wa so a full-memory load reaches MEM_WORDS without wrapping.
    logic [ADDR_W:0]   r_wcnt;
    logic [1:0]        r_bidx;
    logic [23:0]       r_asm;
    logic [ADDR_W-1:0] r_wa;
    logic [31:0]       r_wd;
    logic              r_we;
    logic              r_core_rst_n;
    logic              r_done;
    logic              r_error;

    logic              w_accept_state;
    logic              w_xfer;
    logic [15:0]       w_count;
    logic [ADDR_W:0]   w_wnext;
    logic              w_too_big;
    logic              w_last;

    // Byte acceptance depends only on state; gated by rst_n so it reads 0 while in reset.
    assign w_accept_state = (r_state == S_IDLE) || (r_state == S_CNT_HI) ||
                            (r_state == S_CNT_LO) || (r_state == S_DATA);
    assign rx_ready  = rst_n & w_accept_state;
    assign w_xfer    = rx_valid & rx_ready;
    assign w_count   = {r_cnt_hi, rx_data};
    assign w_too_big = ({16'd0, w_count} > LP_MAX_WORDS);
    assign w_wnext   = r_wcnt + 1'b1;
    assign w_last    = (32'(w_wnext) == 32'(r_count));

    assign wa         = r_wa;
    assign wd         = r_wd;
    assign we         = r_we;
    assign core_rst_n = r_core_rst_n;
    assign done       = r_done;
    assign error      = r_error;

    // Frame parser FSM; the write strobe is raised on entry to WRITE and dropped after one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt_hi     <= 8'd0;
            r_count      <= 16'd0;
            r_wcnt       <= '0;
            r_bidx       <= 2'd0;
            r_asm        <= 24'd0;
            r_wa         <= '0;
            r_wd         <= 32'd0;
            r_we         <= 1'b0;
            r_core_rst_n <= 1'b1;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Non-sync bytes are consumed and dropped.
                    if (w_xfer && rx_data == 8'hA5) begin
                        r_state      <= S_CNT_HI;
                        r_core_rst_n <= 1'b0;
                        r_done       <= 1'b0;
                        r_error      <= 1'b0;
                        r_wcnt       <= '0;
                        r_bidx       <= 2'd0;
                    end
                end
                S_CNT_HI: begin
                    if (w_xfer) begin
                        r_cnt_hi <= rx_data;
                        r_state  <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (w_xfer) begin
                        r_count <= w_count;
                        if (w_count == 16'd0) begin
                            r_state <= S_FINISH;
                        end else if (w_too_big) begin
                            r_state      <= S_IDLE;
                            r_error      <= 1'b1;
                            r_core_rst_n <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_asm  <= {r_asm[15:0], rx_data};
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_we    <= 1'b1;
                            r_wa    <= r_wcnt[ADDR_W-1:0];
                            r_wd    <= {r_asm, rx_data};
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_wcnt  <= w_wnext;
                    r_state <= w_last ? S_FINISH : S_DATA;
                end
                S_FINISH: begin
                    r_done       <= 1'b1;
                    r_core_rst_n <= 1'b1;
                    r_state      <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_loader.sv
// Bench for instruction_loader: directed frames, expected writes queued by the
// stimulus and checked by an independent monitor on each we pulse.
module tb_instruction_loader;

    localparam int ADDR_W    = 4;
    localparam int MEM_WORDS = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        rx_data = 8'd0;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] wa;
    logic [31:0]       wd;
    logic              we;
    logic              core_rst_n;
    logic              done;
    logic              error;

    int n_checks = 0;
    int n_fail   = 0;
    logic [ADDR_W+31:0] sb_q[$];

    instruction_loader #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wa(wa), .wd(wd), .we(we),
        .core_rst_n(core_rst_n), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        sb_q.push_back({a, d});
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (we) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_we", 32'(wa), 32'hFFFF_FFFF);
            end else begin
                logic [ADDR_W+31:0] e;
                e = sb_q.pop_front();
                chk("wr_addr", 32'(wa), 32'(e[ADDR_W+31:32]));
                chk("wr_data", wd, e[31:0]);
            end
        end
    end

    // Starts and ends on a negedge; the byte is taken on the first posedge with rx_ready high.
    task automatic send(input logic [7:0] b);
        int n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 3; i >= 0; i--) begin
            send(w[i*8 +: 8]);
            if (gap != 0) repeat ($urandom_range(1, 5)) @(negedge clk);
        end
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(done), 32'd1);
    endtask

    initial begin
        logic [31:0] w3 [3];
        w3[0] = 32'hA5A5_0102; w3[1] = 32'h0304_A5FF; w3[2] = 32'hCAFE_F00D;

        repeat (2) @(negedge clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_core_rst_n", 32'(core_rst_n), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: two-word frame
        exp_wr(4'd0, 32'hDEAD_BEEF);
        exp_wr(4'd1, 32'h0123_4567);
        send(8'hA5);
        chk("t1_core_rst_low", 32'(core_rst_n), 32'd0);
        send(8'h00); send(8'h02);
        send_word(32'hDEAD_BEEF, 0);
        chk("t1_core_rst_low_mid", 32'(core_rst_n), 32'd0);
        send_word(32'h0123_4567, 0);
        wait_done("t1_done");
        chk("t1_core_rst_rel", 32'(core_rst_n), 32'd1);
        chk("t1_error", 32'(error), 32'd0);

        // 2: empty frame
        send(8'hA5); send(8'h00); send(8'h00);
        repeat (2) @(negedge clk);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_error", 32'(error), 32'd0);
        chk("t2_core_rst", 32'(core_rst_n), 32'd1);

        // 3: count 17 > MEM_WORDS rejected
        send(8'hA5); send(8'h00); send(8'h11);
        @(negedge clk);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_core_rst", 32'(core_rst_n), 32'd1);

        // 4: garbage then one-word frame; also clears error
        send(8'h00); send(8'hFF); send(8'h5A);
        chk("t4_garbage_core_rst", 32'(core_rst_n), 32'd1);
        exp_wr(4'd0, 32'h1122_3344);
        send(8'hA5); send(8'h00); send(8'h01);
        send_word(32'h1122_3344, 0);
        wait_done("t4_done");
        chk("t4_error_clr", 32'(error), 32'd0);

        // 5: three words with random gaps, A5 bytes inside data
        send(8'hA5); send(8'h00); send(8'h03);
        for (int i = 0; i < 3; i++) begin
            exp_wr(ADDR_W'(i), w3[i]);
            send_word(w3[i], 1);
        end
        wait_done("t5_done");

        // boundary: count == MEM_WORDS fills the whole memory
        send(8'hA5); send(8'h00); send(8'h10);
        for (int i = 0; i < 16; i++) begin
            exp_wr(ADDR_W'(i), 32'h5000_0000 + 32'(i * 32'h0101_0101));
            send_word(32'h5000_0000 + 32'(i * 32'h0101_0101), 0);
        end
        wait_done("bnd_done");
        chk("bnd_error", 32'(error), 32'd0);

        // 6: async reset after two data bytes
        send(8'hA5); send(8'h00); send(8'h02);
        send(8'hAA); send(8'hBB);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_we", 32'(we), 32'd0);
        chk("t6_wa", 32'(wa), 32'd0);
        chk("t6_wd", wd, 32'd0);
        chk("t6_rx_ready", 32'(rx_ready), 32'd0);
        chk("t6_core_rst", 32'(core_rst_n), 32'd1);
        chk("t6_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_wr(4'd0, 32'hCAFE_BABE);
        send(8'hA5); send(8'h00); send(8'h01);
        send_word(32'hCAFE_BABE, 0);
        wait_done("t6_done_after");

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
